outport_alloc: RTL
==================

Name: outport_alloc

Overview:
- Per-output-port switch allocator for the router crossbar.
- Arbitrates among the 5 input channels that target this output port and drives their grt_N inputs.
- Uses round-robin selection and holds the grant for a whole packet, head to tail.
- Stalls the grant whenever the downstream VC the packet is locked to is not ready.

Parameters:
- NREQ, 5: number of requesting input channels (local + 4 directions).
- NVC, 2: number of downstream virtual channels.
- VCHW, 1: width of a VC index, clog2(NVC).
- IDW, 3: width of a requester index, clog2(NREQ).

Ports:
- clk  input  1  clock
- rst_  input  1  reset, synchronous, active-high
- req  input  NREQ  req[i]=1: input channel i requests this output port (head flit waiting or packet in progress)
- vch  input  NREQ*VCHW  downstream VC requested by channel i, field i = vch[i*VCHW +: VCHW]
- fvalid  input  NREQ  channel i transfers a flit through the crossbar this cycle
- ftail  input  NREQ  flit of channel i is TAIL or HEADTAIL; qualified by fvalid[i]
- irdy  input  NVC  downstream VC ready, per VC
- grt  output  NREQ  one-hot grant to channel i; all-zero when none
- busy  output  1  port locked to a packet
- owner  output  IDW  index of current owner; meaningful only when busy=1
- ovch  output  VCHW  downstream VC the packet is locked to; meaningful only when busy=1

Behaviour:
- One clock (clk). Reset rst_ is synchronous, active-high.
- Reset values:
  - state=IDLE; busy=0; grt=0; owner=0; ovch=0.
  - Priority pointer ptr=NREQ-1, so requester 0 has highest priority after reset.
- Eligibility: requester i is eligible when req[i]=1 and irdy[vch field i]=1.
- State IDLE:
  - If any requester is eligible, pick the first eligible index scanning ptr+1, ptr+2, … modulo NREQ (wraps from NREQ-1 to 0).
  - Register owner=pick and ovch=vch field of pick; go to BUSY.
  - If none is eligible, stay in IDLE.
  - grt=0 throughout IDLE.
- State BUSY:
  - grt[owner]=irdy[ovch]; all other grt bits are 0.
  - grt is combinational from registered state and irdy.
  - Latency: req asserted in cycle t while IDLE -> grt high in cycle t+1, provided irdy is still high.
- Transfer: flit accepted when busy & grt[owner] & fvalid[owner].
- Release conditions; each takes effect next cycle (go to IDLE, ptr=owner, so the last owner gets lowest priority):
  - Accepted flit with ftail[owner]=1. Single-flit HEADTAIL packet: grant lasts until that flit, i.e. one grant cycle if irdy is high.
  - req[owner]=0 while busy (abort).
- After a release, the earliest new grant is 2 cycles after the tail cycle: the IDLE cycle plus 1.
- fvalid/ftail from non-owners are ignored. ftail without fvalid is ignored. fvalid[owner] while grt[owner]=0 is ignored and does not count as a transfer.
- Irdy drop mid-packet: grt drops the same cycle; state, owner and ovch are held; the grant resumes when irdy returns. No timeout.
- Changes of vch of the owner while busy are ignored; ovch stays locked.
- Reset mid-packet: the next cycle is IDLE with ptr=NREQ-1, regardless of in-flight flits.
- Invariants (for assertions):
  - popcount(grt)<=1.
  - grt!=0 implies busy.
  - owner and ovch are stable while busy.

Test Plan:
- Single request: rst_ pulse, then req=5'b00100, vch=ch2->VC1, irdy=2'b11. Expect busy=1 and grt=5'b00100 one cycle later, owner=2, ovch=1. A 3-flit packet with ftail on the 3rd accepted flit -> busy=0 next cycle.
- Round-robin fairness: req=5'b11111 held, each channel sends 1-flit HEADTAIL packets. Expect grant order 0,1,2,3,4,0,… with a gap of one IDLE cycle between grants.
- Wrap-around: ptr=4 after channel 4 finishes, req=5'b10001. Expect channel 0 granted next, then channel 4.
- Downstream stall: owner=1 locked on VC0, irdy[0] low for 3 cycles mid-packet. Expect grt=0 for those 3 cycles, busy=1, owner=1 held. Flits offered with fvalid during the stall are not counted. The grant resumes and the tail then releases the port.
- Ineligible skip: req=5'b00011, ch0 wants VC0 with irdy=2'b10, ch1 wants VC1. Expect ch1 granted, ovch=1.
- Abort and reset: owner=3 drops req mid-packet -> IDLE next cycle, ptr=3. Separately, rst_ asserted while busy -> busy=0 and grt=0 next cycle; then req=5'b11111 -> channel 0 granted.

Source files
------------

// File: rtl/outport_alloc_if.sv
// Handshake bundle between the five input channels / downstream VCs and one
// output-port allocator. The slave side is the allocator.
interface outport_alloc_if #(
   parameter int NREQ = 5,
   parameter int NVC  = 2,
   parameter int VCHW = 1,
   parameter int IDW  = 3
);
   logic [NREQ-1:0]      req;
   logic [NREQ*VCHW-1:0] vch;
   logic [NREQ-1:0]      fvalid;
   logic [NREQ-1:0]      ftail;
   logic [NVC-1:0]       irdy;
   logic [NREQ-1:0]      grt;
   logic                 busy;
   logic [IDW-1:0]       owner;
   logic [VCHW-1:0]      ovch;

   modport master (
      output req, vch, fvalid, ftail, irdy,
      input  grt, busy, owner, ovch
   );

   modport slave (
      input  req, vch, fvalid, ftail, irdy,
      output grt, busy, owner, ovch
   );
endinterface

// File: rtl/outport_alloc.sv
// Round-robin switch allocator for one crossbar output port. A grant is held
// from head to tail and gated by the ready of the VC the packet is locked to.
module outport_alloc #(
   parameter int NREQ = 5,
   parameter int NVC  = 2,
   parameter int VCHW = 1,
   parameter int IDW  = 3
) (
   input  logic           clk,
   input  logic           rst_,
   outport_alloc_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_reg, state_next;
   logic [IDW-1:0]  owner_reg, owner_next;
   logic [VCHW-1:0] ovch_reg, ovch_next;
   logic [IDW-1:0]  ptr_reg, ptr_next;

   logic [NVC-1:0]  irdy;
   logic [VCHW-1:0] vch_arr [NREQ];
   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] grt_vec;

   logic            found;
   logic [IDW-1:0]  pick;
   logic [IDW:0]    cand;

   logic            busy;
   logic            own_grt;
   logic            own_req;
   logic            own_fv;
   logic            own_ft;
   logic            accept;
   logic            rel;

   assign irdy = bus.irdy;
   assign busy = (state_reg == BUSY);

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign vch_arr[gi] = bus.vch[gi*VCHW +: VCHW];
      assign elig[gi]    = bus.req[gi] & irdy[vch_arr[gi]];
      assign grt_vec[gi] = busy && (owner_reg == IDW'(gi)) && irdy[ovch_reg];
   end

   // First eligible requester after the pointer; candidates fold back past NREQ-1.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = {1'b0, ptr_reg} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         if (!found && elig[cand[IDW-1:0]]) begin
            found = 1'b1;
            pick  = cand[IDW-1:0];
         end
      end
   end

   assign own_grt = busy & irdy[ovch_reg];
   assign own_req = bus.req[owner_reg];
   assign own_fv  = bus.fvalid[owner_reg];
   assign own_ft  = bus.ftail[owner_reg];
   assign accept  = own_grt & own_fv;
   assign rel     = busy & ((accept & own_ft) | ~own_req);

   always_comb begin
      state_next = state_reg;
      owner_next = owner_reg;
      ovch_next  = ovch_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         IDLE: begin
            if (found) begin
               state_next = BUSY;
               owner_next = pick;
               ovch_next  = vch_arr[pick];
            end
         end
         BUSY: begin
            // Last owner becomes lowest priority for the next round.
            if (rel) begin
               state_next = IDLE;
               ptr_next   = owner_reg;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_) begin
         state_reg <= IDLE;
         owner_reg <= '0;
         ovch_reg  <= '0;
         ptr_reg   <= IDW'(NREQ-1);
      end else begin
         state_reg <= state_next;
         owner_reg <= owner_next;
         ovch_reg  <= ovch_next;
         ptr_reg   <= ptr_next;
      end
   end

   assign bus.grt   = grt_vec;
   assign bus.busy  = busy;
   assign bus.owner = owner_reg;
   assign bus.ovch  = ovch_reg;
endmodule
